// File: rtl/lab72_timer_pkg.sv
// Shared definitions for the lab72 interval-timer master: slave word map,
// control bit positions, FSM states and the bus command record.
package lab72_timer_pkg;

   localparam logic [3:0] ADDR_STATUS  = 4'd0;
   localparam logic [3:0] ADDR_CONTROL = 4'd1;
   localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
   localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
   localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
   localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
   localparam logic [3:0] ADDR_SNAP0   = 4'd6;
   localparam logic [3:0] ADDR_SNAP1   = 4'd7;
   localparam logic [3:0] ADDR_SNAP2   = 4'd8;
   localparam logic [3:0] ADDR_SNAP3   = 4'd9;

   localparam int ITO   = 0;
   localparam int CONT  = 1;
   localparam int START = 2;
   localparam int STOP  = 3;

   // Stop bit set, interrupt enable cleared.
   localparam logic [15:0] CTRL_STOP_WORD = 16'(1) << STOP;

   typedef enum logic [3:0] {
      IDLE,
      WR_P0,
      WR_P1,
      WR_P2,
      WR_P3,
      WR_CTRL,
      RUN,
      CLR_STAT,
      CLR_WAIT,
      WR_STOP
`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
      ,
      SNAP_WR,
      SNAP_RD0,
      SNAP_RD1,
      SNAP_RD2,
      SNAP_RD3,
      SNAP_CAP
`endif
   } state_e;

   typedef struct packed {
      logic        en;
      logic        wr;
      logic [3:0]  addr;
      logic [15:0] data;
   } avm_cmd_t;

   localparam avm_cmd_t AVM_IDLE = '{en: 1'b0, wr: 1'b0, addr: 4'd0, data: 16'h0};

   function automatic avm_cmd_t avm_write(input logic [3:0] addr, input logic [15:0] data);
      avm_cmd_t c;
      c.en   = 1'b1;
      c.wr   = 1'b1;
      c.addr = addr;
      c.data = data;
      return c;
   endfunction

   function automatic avm_cmd_t avm_read(input logic [3:0] addr);
      avm_cmd_t c;
      c.en   = 1'b1;
      c.wr   = 1'b0;
      c.addr = addr;
      c.data = 16'h0;
      return c;
   endfunction

endpackage

// File: rtl/lab72_timer_master_if.sv
// Avalon-MM slave-port signals between the timer master and the interval timer.
interface lab72_timer_master_if;
   logic [3:0]  av_address;
   logic        av_chipselect;
   logic        av_write_n;
   logic [15:0] av_writedata;
   logic [15:0] av_readdata;

   modport master (
      output av_address,
      output av_chipselect,
      output av_write_n,
      output av_writedata,
      input  av_readdata
   );

   modport slave (
      input  av_address,
      input  av_chipselect,
      input  av_write_n,
      input  av_writedata,
      output av_readdata
   );
endinterface

// File: rtl/lab72_avm_write_port.sv
// Output register stage for the Avalon-MM master: one access per command,
// bus parked idle (cs low, write_n high, data zero) whenever no command is issued.
module lab72_avm_write_port
   import lab72_timer_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  avm_cmd_t                    cmd,
   lab72_timer_master_if.master        bus
);

   logic [3:0]  address_q;
   logic        chipselect_q;
   logic        write_n_q;
   logic [15:0] writedata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         address_q    <= ADDR_STATUS;
         chipselect_q <= 1'b0;
         write_n_q    <= 1'b1;
         writedata_q  <= 16'h0;
      end else begin
         address_q    <= cmd.en ? cmd.addr : ADDR_STATUS;
         chipselect_q <= cmd.en;
         write_n_q    <= !(cmd.en && cmd.wr);
         writedata_q  <= (cmd.en && cmd.wr) ? cmd.data : 16'h0;
      end
   end

   assign bus.av_address    = address_q;
   assign bus.av_chipselect = chipselect_q;
   assign bus.av_write_n    = write_n_q;
   assign bus.av_writedata  = writedata_q;

endmodule

// File: rtl/lab72_timer_master.sv
// Hardware master for the lab72 interval timer: programs period, starts, services
// timeouts and counts ticks. Snapshot readout enabled by LAB72_TIMER_MASTER_SNAPSHOT_EN.
//
//   state     | meaning
//   IDLE      | waiting for start
//   WR_P0..3  | writing period halfwords to addresses 2..5
//   WR_CTRL   | writing control: start, continuous, interrupt enable
//   RUN       | timer counting, waiting for irq / stop / snapshot
//   CLR_STAT  | status write clears the timeout, tick pulse
//   CLR_WAIT  | idle cycle so the registered irq can drop
//   WR_STOP   | control write with stop bit, back to IDLE
//   SNAP_WR   | snapshot latch write to address 6
//   SNAP_RD0..3 | reading snapshot halfwords 6..9
//   SNAP_CAP  | trailing capture of the last halfword
module lab72_timer_master
   import lab72_timer_pkg::*;
#(
   parameter int TICK_W   = 32,
   parameter bit CTRL_ITO = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [63:0]          period,
   input  logic                 continuous,
   output logic                 busy,
   output logic                 running,
   output logic                 tick,
   output logic [TICK_W-1:0]    tick_count,
   lab72_timer_master_if.master bus,
   input  logic                 timer_irq
`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
   ,
   input  logic                 snap_req,
   output logic                 snap_valid,
   output logic [63:0]          snap_value
`endif
);

   state_e              state_q, state_d;
   logic                stop_pending_q, stop_pending_d;
   logic [63:16]        period_hi_q;
   logic                cont_q;
   logic                busy_q, running_q, tick_q;
   logic [TICK_W-1:0]   tick_count_q;
   logic                tick_d;
   avm_cmd_t            cmd;

   lab72_avm_write_port u_write_port (
      .clk   (clk),
      .reset (reset),
      .cmd   (cmd),
      .bus   (bus)
   );

   // Commands are decoded on the transition so the bus shows each access
   // during the cycle the FSM sits in the matching state.
   always_comb begin
      state_d        = state_q;
      stop_pending_d = stop_pending_q;
      cmd            = AVM_IDLE;
      if (stop && state_q != IDLE && state_q != WR_STOP)
         stop_pending_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WR_P0;
               cmd     = avm_write(ADDR_PERIOD0, period[15:0]);
            end
         end
         WR_P0: begin
            state_d = WR_P1;
            cmd     = avm_write(ADDR_PERIOD1, period_hi_q[31:16]);
         end
         WR_P1: begin
            state_d = WR_P2;
            cmd     = avm_write(ADDR_PERIOD2, period_hi_q[47:32]);
         end
         WR_P2: begin
            state_d = WR_P3;
            cmd     = avm_write(ADDR_PERIOD3, period_hi_q[63:48]);
         end
         WR_P3: begin
            state_d = WR_CTRL;
            cmd     = avm_write(ADDR_CONTROL, {12'b0, 1'b0, 1'b1, cont_q, CTRL_ITO});
         end
         WR_CTRL: state_d = RUN;
         RUN: begin
            if (timer_irq) begin
               state_d = CLR_STAT;
               cmd     = avm_write(ADDR_STATUS, 16'h0);
            end else if (stop || stop_pending_q) begin
               state_d = WR_STOP;
               cmd     = avm_write(ADDR_CONTROL, CTRL_STOP_WORD);
            end
`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
            else if (snap_req) begin
               state_d = SNAP_WR;
               cmd     = avm_write(ADDR_SNAP0, 16'h0);
            end
`endif
         end
         CLR_STAT: begin
            if (stop_pending_q || !cont_q) begin
               state_d = WR_STOP;
               cmd     = avm_write(ADDR_CONTROL, CTRL_STOP_WORD);
            end else begin
               state_d = CLR_WAIT;
            end
         end
         CLR_WAIT: state_d = RUN;
         WR_STOP: begin
            state_d        = IDLE;
            stop_pending_d = 1'b0;
         end
`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
         SNAP_WR: begin
            state_d = SNAP_RD0;
            cmd     = avm_read(ADDR_SNAP0);
         end
         SNAP_RD0: begin
            state_d = SNAP_RD1;
            cmd     = avm_read(ADDR_SNAP1);
         end
         SNAP_RD1: begin
            state_d = SNAP_RD2;
            cmd     = avm_read(ADDR_SNAP2);
         end
         SNAP_RD2: begin
            state_d = SNAP_RD3;
            cmd     = avm_read(ADDR_SNAP3);
         end
         SNAP_RD3: state_d = SNAP_CAP;
         SNAP_CAP: state_d = RUN;
`endif
         default: state_d = IDLE;
      endcase
   end

   assign tick_d = (state_q == RUN) && (state_d == CLR_STAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         stop_pending_q <= 1'b0;
         period_hi_q    <= '0;
         cont_q         <= 1'b0;
         busy_q         <= 1'b0;
         running_q      <= 1'b0;
         tick_q         <= 1'b0;
         tick_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         stop_pending_q <= stop_pending_d;
         busy_q         <= (state_d != IDLE);
         running_q      <= (state_d == RUN) || (state_d == CLR_STAT);
         tick_q         <= tick_d;
         if (state_q == IDLE && start) begin
            period_hi_q  <= period[63:16];
            cont_q       <= continuous;
            tick_count_q <= '0;
         end else if (tick_d) begin
            tick_count_q <= tick_count_q + TICK_W'(1);
         end
      end
   end

   assign busy       = busy_q;
   assign running    = running_q;
   assign tick       = tick_q;
   assign tick_count = tick_count_q;

`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
   logic [63:0] snap_value_q;
   logic        snap_valid_q;

   // Read data is registered in the slave: each halfword lands one state late.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_value_q <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         snap_valid_q <= (state_q == SNAP_CAP);
         case (state_q)
            SNAP_RD1: snap_value_q[15:0]  <= bus.av_readdata;
            SNAP_RD2: snap_value_q[31:16] <= bus.av_readdata;
            SNAP_RD3: snap_value_q[47:32] <= bus.av_readdata;
            SNAP_CAP: snap_value_q[63:48] <= bus.av_readdata;
            default: ;
         endcase
      end
   end

   assign snap_value = snap_value_q;
   assign snap_valid = snap_valid_q;
`else
   logic unused_readdata;
   assign unused_readdata = ^bus.av_readdata;
`endif

endmodule

// File: tb/tb_lab72_timer_master.sv
// Directed bench for lab72_timer_master with a behavioural interval-timer slave
// and a scoreboard of expected bus writes.
module tb_lab72_timer_master;
   import lab72_timer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [63:0] period = 64'h0;
   logic        continuous = 1'b0;
   logic        timer_irq = 1'b0;
   logic        busy, running, tick;
   logic [31:0] tick_count;
`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
   logic        snap_req = 1'b0;
   logic        snap_valid;
   logic [63:0] snap_value;
`endif

   lab72_timer_master_if bus ();

   lab72_timer_master dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .period     (period),
      .continuous (continuous),
      .busy       (busy),
      .running    (running),
      .tick       (tick),
      .tick_count (tick_count),
      .bus        (bus),
      .timer_irq  (timer_irq)
`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
      ,
      .snap_req   (snap_req),
      .snap_valid (snap_valid),
      .snap_value (snap_value)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int tick_seen = 0;
   int snap_pulses = 0;

   typedef struct packed {
      logic [3:0]  a;
      logic [15:0] d;
   } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic [3:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic push_prog(input logic [63:0] p, input logic c);
      push_wr(4'd2, p[15:0]);
      push_wr(4'd3, p[31:16]);
      push_wr(4'd4, p[47:32]);
      push_wr(4'd5, p[63:48]);
      push_wr(4'd1, c ? 16'h0007 : 16'h0005);
   endtask

   task automatic do_start(input logic [63:0] p, input logic c);
      period     = p;
      continuous = c;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, {63'h0, busy}, 64'h0);
   endtask

   // Behavioural interval timer: registered irq and registered read data.
   logic [63:0] tm_period = 64'h0;
   logic [63:0] tm_cnt = 64'h0;
   logic        tm_run = 1'b0;
   logic        tm_cont = 1'b0;

   always @(posedge clk) begin
      if (bus.av_chipselect === 1'b1 && bus.av_write_n === 1'b0) begin
         case (bus.av_address)
            4'd0: timer_irq <= 1'b0;
            4'd1: begin
               if (bus.av_writedata[3]) tm_run <= 1'b0;
               else if (bus.av_writedata[2]) begin
                  tm_run  <= 1'b1;
                  tm_cnt  <= tm_period;
                  tm_cont <= bus.av_writedata[1];
               end
            end
            4'd2: tm_period[15:0]  <= bus.av_writedata;
            4'd3: tm_period[31:16] <= bus.av_writedata;
            4'd4: tm_period[47:32] <= bus.av_writedata;
            4'd5: tm_period[63:48] <= bus.av_writedata;
            default: ;
         endcase
      end else if (tm_run) begin
         if (tm_cnt == 64'h0) begin
            timer_irq <= 1'b1;
            if (tm_cont) tm_cnt <= tm_period;
            else tm_run <= 1'b0;
         end else begin
            tm_cnt <= tm_cnt - 64'h1;
         end
      end
      if (bus.av_chipselect === 1'b1 && bus.av_write_n === 1'b1) begin
         case (bus.av_address)
            4'd6: bus.av_readdata <= 16'h1111;
            4'd7: bus.av_readdata <= 16'h2222;
            4'd8: bus.av_readdata <= 16'h3333;
            4'd9: bus.av_readdata <= 16'h4444;
            default: bus.av_readdata <= 16'h0;
         endcase
      end else begin
         bus.av_readdata <= 16'h0;
      end
   end

   // Bus monitor: every write popped from the scoreboard, idle bus checked.
   always @(negedge clk) begin
      if (!reset) begin
         if (tick === 1'b1) tick_seen++;
`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
         if (snap_valid === 1'b1) snap_pulses++;
`endif
         if (bus.av_chipselect === 1'b1 && bus.av_write_n === 1'b0) begin
            check("write_expected", {63'h0, exp_q.size() != 0}, 64'h1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("bus_write", {44'h0, bus.av_address, bus.av_writedata}, {44'h0, mon_e});
               if (bus.av_address === 4'd0) check("tick_with_status", {63'h0, tick}, 64'h1);
            end
         end else if (bus.av_chipselect !== 1'b1) begin
            check("bus_idle", {47'h0, bus.av_write_n, bus.av_writedata}, {47'h0, 1'b1, 16'h0});
         end
      end
   end

   int base;
   int n;
   logic [3:0] prog_addr [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};

   initial begin
      bus.av_readdata = 16'h0;
      repeat (2) @(negedge clk);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_running", {63'h0, running}, 64'h0);
      check("rst_tick", {63'h0, tick}, 64'h0);
      check("rst_tick_count", {32'h0, tick_count}, 64'h0);
      check("rst_bus", {43'h0, bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata},
            {43'h0, 1'b0, 1'b1, 4'd0, 16'h0});
      reset = 1'b0;
      @(negedge clk);

      // Programming sequence followed by periodic servicing.
      base = tick_seen;
      push_prog(64'h9, 1'b1);
      push_wr(4'd0, 16'h0);
      push_wr(4'd0, 16'h0);
      push_wr(4'd0, 16'h0);
      do_start(64'h9, 1'b1);
      for (int k = 0; k < 5; k++) begin
         check("prog_addr", {59'h0, bus.av_chipselect, bus.av_address}, {59'h0, 1'b1, prog_addr[k]});
         @(negedge clk);
      end
      check("prog_running", {62'h0, busy, running}, {62'h0, 2'b11});
      n = 0;
      while (tick_count !== 32'd3 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("periodic_count", {32'h0, tick_count}, 64'd3);
      check("periodic_running", {63'h0, running}, 64'h1);
      push_wr(4'd1, 16'h0008);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_idle("periodic_stop_idle", 50);
      check("periodic_ticks", tick_seen - base, 64'd3);
      check("periodic_count_kept", {32'h0, tick_count}, 64'd3);

      // One-shot.
      base = tick_seen;
      push_prog(64'h5, 1'b0);
      push_wr(4'd0, 16'h0);
      push_wr(4'd1, 16'h0008);
      do_start(64'h5, 1'b0);
      check("oneshot_count_cleared", {32'h0, tick_count}, 64'd0);
      wait_idle("oneshot_idle", 100);
      @(negedge clk);
      check("oneshot_count", {32'h0, tick_count}, 64'd1);
      check("oneshot_ticks", tick_seen - base, 64'd1);

      // Stop during programming.
      base = tick_seen;
      push_prog(64'h9, 1'b1);
      push_wr(4'd1, 16'h0008);
      do_start(64'h9, 1'b1);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (4) @(negedge clk);
      check("early_stop_write", {43'h0, bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata},
            {43'h0, 1'b1, 1'b0, 4'd1, 16'h0008});
      @(negedge clk);
      check("early_stop_idle", {63'h0, busy}, 64'h0);
      check("early_stop_count", {32'h0, tick_count}, 64'd0);
      check("early_stop_ticks", tick_seen - base, 64'd0);

      // Start mid-run ignored, then stop coinciding with irq.
      base = tick_seen;
      push_prog(64'h9, 1'b1);
      push_wr(4'd0, 16'h0);
      do_start(64'h9, 1'b1);
      n = 0;
      while (tick_count !== 32'd1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_first_tick", {32'h0, tick_count}, 64'd1);
      repeat (3) @(negedge clk);
      do_start(64'h55, 1'b0);
      check("mid_start_count", {32'h0, tick_count}, 64'd1);
      check("mid_start_busy", {63'h0, busy}, 64'h1);
      push_wr(4'd0, 16'h0);
      push_wr(4'd1, 16'h0008);
      n = 0;
      while (timer_irq !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_irq_seen", {63'h0, timer_irq}, 64'h1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_idle("mid_stop_idle", 50);
      check("mid_count", {32'h0, tick_count}, 64'd2);
      check("mid_ticks", tick_seen - base, 64'd2);

      // Reset in the middle of programming.
      push_wr(4'd2, 16'h0009);
      push_wr(4'd3, 16'h0000);
      do_start(64'h9, 1'b1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_outputs", {61'h0, busy, bus.av_chipselect, bus.av_write_n}, {61'h0, 3'b001});
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_stays_idle", {62'h0, busy, bus.av_chipselect}, 64'h0);

`ifdef LAB72_TIMER_MASTER_SNAPSHOT_EN
      push_prog(64'd1000, 1'b1);
      push_wr(4'd6, 16'h0);
      do_start(64'd1000, 1'b1);
      repeat (5) @(negedge clk);
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      n = 0;
      while (snap_valid !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("snap_valid", {63'h0, snap_valid}, 64'h1);
      check("snap_value", snap_value, 64'h4444_3333_2222_1111);
      @(negedge clk);
      check("snap_valid_drop", {63'h0, snap_valid}, 64'h0);
      push_wr(4'd1, 16'h0008);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_idle("snap_stop_idle", 50);
      check("snap_pulses", snap_pulses, 64'd1);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
